// File: rtl/pe_pkg.sv
// Shared definitions for the load/store memory sequencer: FSM states,
// funct3 encodings, response error bit positions and the funct3 legality check.
package pe_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    ACC1 = 3'd2,
    ACC2 = 3'd3,
    RESP = 3'd4
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam int unsigned ERR_MISALIGN = 0;
  localparam int unsigned ERR_TIMEOUT  = 1;
  localparam int unsigned ERR_W        = 2;

  // Doubleword and unsigned-word forms exist only on a 64-bit data path.
  function automatic logic funct3_legal(input logic store, input logic [2:0] f3,
                                        input logic xlen64);
    logic ok;
    ok = 1'b0;
    if (store) begin
      case (f3)
        F3_B, F3_H, F3_W: ok = 1'b1;
        F3_D:             ok = xlen64;
        default:          ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
        F3_D, F3_WU:                    ok = xlen64;
        default:                        ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/pe_lane_align.sv
// Byte-lane steering for the sequencer: store data/byte-enable placement across
// two adjacent words, and merge plus sign/zero extension of returned load data.
module pe_lane_align
  import pe_pkg::*;
#(
  parameter  int unsigned XLEN = 32,
  localparam int unsigned NB   = XLEN / 8,
  localparam int unsigned OW   = $clog2(NB)
) (
  input  logic [2:0]      funct3,
  input  logic [OW-1:0]   offset,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata_lo,
  input  logic [XLEN-1:0] rdata_hi,
  output logic [NB-1:0]   be_lo_c,
  output logic [NB-1:0]   be_hi_c,
  output logic [XLEN-1:0] wdata_lo_c,
  output logic [XLEN-1:0] wdata_hi_c,
  output logic            cross_c,
  output logic [XLEN-1:0] load_data_c
);

  localparam int unsigned BW = 2 * NB;
  localparam int unsigned DW = 2 * XLEN;

  logic [OW+2:0]   sh;
  logic [BW-1:0]   size_be;
  logic [BW-1:0]   be_wide;
  logic [XLEN-1:0] wmask;
  logic [DW-1:0]   wdata_wide;
  logic [XLEN-1:0] raw;
  logic            sgn;

  assign sh  = {offset, 3'b000};
  assign sgn = ~funct3[2];

  // Access size from funct3[1:0]: 1, 2, 4 or 8 bytes.
  always_comb begin
    size_be = '0;
    wmask   = '0;
    case (funct3[1:0])
      2'b00: begin size_be = BW'(1);     wmask = XLEN'(8'hFF);         end
      2'b01: begin size_be = BW'(3);     wmask = XLEN'(16'hFFFF);      end
      2'b10: begin size_be = BW'(4'hF);  wmask = XLEN'(32'hFFFF_FFFF); end
      default: begin size_be = BW'(8'hFF); wmask = '1;                 end
    endcase
  end

  assign be_wide    = size_be << offset;
  assign be_lo_c    = be_wide[NB-1:0];
  assign be_hi_c    = be_wide[BW-1:NB];
  assign cross_c    = |be_hi_c;
  assign wdata_wide = DW'(wdata & wmask) << sh;
  assign wdata_lo_c = wdata_wide[XLEN-1:0];
  assign wdata_hi_c = wdata_wide[DW-1:XLEN];

  // Bytes of a split load straddle both words; shift the pair down as one.
  assign raw = XLEN'({rdata_hi, rdata_lo} >> sh);

  always_comb begin
    load_data_c = raw;
    case (funct3[1:0])
      2'b00:   load_data_c = sgn ? XLEN'($signed(raw[7:0]))  : XLEN'(raw[7:0]);
      2'b01:   load_data_c = sgn ? XLEN'($signed(raw[15:0])) : XLEN'(raw[15:0]);
      2'b10:   load_data_c = sgn ? XLEN'($signed(raw[31:0])) : XLEN'(raw[31:0]);
      default: load_data_c = raw;
    endcase
  end

endmodule

// File: rtl/pe_mem_sequencer.sv
// Single-outstanding load/store sequencer: address generation, optional split of
// word-crossing accesses, per-access ack timeout and a one-cycle response.
module pe_mem_sequencer
  import pe_pkg::*;
#(
  parameter  int unsigned XLEN             = 32,
  parameter  int unsigned TIMEOUT_CYCLES   = 15,
  parameter  int unsigned SPLIT_MISALIGNED = 1,
  localparam int unsigned NB               = XLEN / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [4:0]        req_rd,
  input  logic [XLEN-1:0]   req_base,
  input  logic [11:0]       req_imm12,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [XLEN-1:0]   mem_address,
  output logic [NB-1:0]     mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic              rsp_valid,
  output logic [4:0]        rsp_rd,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_write,
  output logic [ERR_W-1:0]  rsp_err,
  output logic              busy
);

  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   base_q, base_d;
  logic [11:0]       imm_q, imm_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [OW-1:0]     off_q, off_d;
  logic              split_q, split_d;
  logic [NB-1:0]     be_hi_q, be_hi_d;
  logic [XLEN-1:0]   wdata_hi_q, wdata_hi_d;
  logic [XLEN-1:0]   rdata_lo_q, rdata_lo_d;
  logic [WW-1:0]     wait_q, wait_d;

  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [XLEN-1:0]   mem_address_q, mem_address_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [4:0]        rsp_rd_q, rsp_rd_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic              rsp_write_q, rsp_write_d;
  logic [ERR_W-1:0]  rsp_err_q, rsp_err_d;

  logic [XLEN-1:0]   ea_c;
  logic [OW-1:0]     off_c;
  logic              legal_c;
  logic [XLEN-1:0]   lane_lo_c, lane_hi_c;
  logic [NB-1:0]     be_lo_c, be_hi_c;
  logic [XLEN-1:0]   wdata_lo_c, wdata_hi_c;
  logic              cross_c;
  logic [XLEN-1:0]   load_data_c;
  logic [ERR_W-1:0]  err_c;
  logic [XLEN-1:0]   ldata_c;

  assign ea_c      = base_q + XLEN'($signed(imm_q));
  assign off_c     = (state_q == ADDR) ? ea_c[OW-1:0] : off_q;
  assign legal_c   = funct3_legal(store_q, funct3_q, XLEN == 64);
  assign lane_lo_c = (state_q == ACC2) ? rdata_lo_q : mem_rdata;
  assign lane_hi_c = (state_q == ACC2) ? mem_rdata  : '0;

  pe_lane_align #(.XLEN(XLEN)) u_lane_align (
    .funct3      (funct3_q),
    .offset      (off_c),
    .wdata       (wdata_q),
    .rdata_lo    (lane_lo_c),
    .rdata_hi    (lane_hi_c),
    .be_lo_c     (be_lo_c),
    .be_hi_c     (be_hi_c),
    .wdata_lo_c  (wdata_lo_c),
    .wdata_hi_c  (wdata_hi_c),
    .cross_c     (cross_c),
    .load_data_c (load_data_c)
  );

  // Next state, request latching and registered output values.
  always_comb begin
    state_d       = state_q;
    store_d       = store_q;
    funct3_d      = funct3_q;
    rd_d          = rd_q;
    base_d        = base_q;
    imm_d         = imm_q;
    wdata_d       = wdata_q;
    off_d         = off_q;
    split_d       = split_q;
    be_hi_d       = be_hi_q;
    wdata_hi_d    = wdata_hi_q;
    rdata_lo_d    = rdata_lo_q;
    wait_d        = wait_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    err_c         = '0;
    ldata_c       = '0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          rd_d     = req_rd;
          base_d   = req_base;
          imm_d    = req_imm12;
          wdata_d  = req_wdata;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        off_d      = ea_c[OW-1:0];
        split_d    = cross_c;
        be_hi_d    = be_hi_c;
        wdata_hi_d = wdata_hi_c;
        if (!legal_c || (cross_c && SPLIT_MISALIGNED == 0)) begin
          state_d             = RESP;
          err_c[ERR_MISALIGN] = 1'b1;
        end else begin
          state_d       = ACC1;
          wait_d        = '0;
          mem_read_d    = !store_q;
          mem_write_d   = store_q;
          mem_address_d = {ea_c[XLEN-1:OW], OW'(0)};
          mem_be_d      = be_lo_c;
          mem_wdata_d   = store_q ? wdata_lo_c : '0;
        end
      end
      ACC1, ACC2: begin
        // An ack in the last counted cycle still wins over the timeout.
        if (mem_ack) begin
          if (state_q == ACC1 && split_q) begin
            state_d       = ACC2;
            rdata_lo_d    = mem_rdata;
            wait_d        = '0;
            mem_address_d = mem_address_q + XLEN'(NB);
            mem_be_d      = be_hi_q;
            mem_wdata_d   = wdata_hi_q;
          end else begin
            state_d = RESP;
            ldata_c = store_q ? '0 : load_data_c;
          end
        end else if (wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
          state_d            = RESP;
          err_c[ERR_TIMEOUT] = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == RESP) begin
      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
      mem_address_d = '0;
      mem_be_d      = '0;
      mem_wdata_d   = '0;
    end

    rsp_valid_d = (state_d == RESP);
    rsp_rd_d    = (state_d == RESP) ? rd_q : '0;
    rsp_err_d   = err_c;
    rsp_data_d  = ldata_c;
    rsp_write_d = (state_d == RESP) && !store_q && (err_c == '0);
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      store_q       <= 1'b0;
      funct3_q      <= '0;
      rd_q          <= '0;
      base_q        <= '0;
      imm_q         <= '0;
      wdata_q       <= '0;
      off_q         <= '0;
      split_q       <= 1'b0;
      be_hi_q       <= '0;
      wdata_hi_q    <= '0;
      rdata_lo_q    <= '0;
      wait_q        <= '0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_be_q      <= '0;
      mem_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rd_q      <= '0;
      rsp_data_q    <= '0;
      rsp_write_q   <= 1'b0;
      rsp_err_q     <= '0;
    end else begin
      state_q       <= state_d;
      store_q       <= store_d;
      funct3_q      <= funct3_d;
      rd_q          <= rd_d;
      base_q        <= base_d;
      imm_q         <= imm_d;
      wdata_q       <= wdata_d;
      off_q         <= off_d;
      split_q       <= split_d;
      be_hi_q       <= be_hi_d;
      wdata_hi_q    <= wdata_hi_d;
      rdata_lo_q    <= rdata_lo_d;
      wait_q        <= wait_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rd_q      <= rsp_rd_d;
      rsp_data_q    <= rsp_data_d;
      rsp_write_q   <= rsp_write_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rd      = rsp_rd_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_pe_mem_sequencer.sv
// Directed bench for pe_mem_sequencer: three instances (32-bit split with short
// timeout, 32-bit no-split, 64-bit) driven through hand-computed transactions.
module tb_pe_mem_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        va, vb, vc;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic [11:0] req_imm12;
  logic [31:0] base32, wdata32, rdata32;
  logic [63:0] base64, wdata64, rdata64;
  logic        mem_ack;

  logic        a_req_ready, a_mem_read, a_mem_write, a_rsp_valid, a_rsp_write, a_busy;
  logic [31:0] a_mem_address, a_mem_wdata, a_rsp_data;
  logic [3:0]  a_mem_be;
  logic [4:0]  a_rsp_rd;
  logic [1:0]  a_rsp_err;

  logic        b_req_ready, b_mem_read, b_mem_write, b_rsp_valid, b_rsp_write, b_busy;
  logic [31:0] b_mem_address, b_mem_wdata, b_rsp_data;
  logic [3:0]  b_mem_be;
  logic [4:0]  b_rsp_rd;
  logic [1:0]  b_rsp_err;

  logic        c_req_ready, c_mem_read, c_mem_write, c_rsp_valid, c_rsp_write, c_busy;
  logic [63:0] c_mem_address, c_mem_wdata, c_rsp_data;
  logic [7:0]  c_mem_be;
  logic [4:0]  c_rsp_rd;
  logic [1:0]  c_rsp_err;

  int total = 0;
  int bad   = 0;

  pe_mem_sequencer #(.XLEN(32), .TIMEOUT_CYCLES(4), .SPLIT_MISALIGNED(1)) dut_a (
    .clk(clk), .reset(rst_n), .req_valid(va), .req_ready(a_req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_rd(req_rd),
    .req_base(base32), .req_imm12(req_imm12), .req_wdata(wdata32),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_address(a_mem_address),
    .mem_be(a_mem_be), .mem_wdata(a_mem_wdata), .mem_rdata(rdata32), .mem_ack(mem_ack),
    .rsp_valid(a_rsp_valid), .rsp_rd(a_rsp_rd), .rsp_data(a_rsp_data),
    .rsp_write(a_rsp_write), .rsp_err(a_rsp_err), .busy(a_busy)
  );

  pe_mem_sequencer #(.XLEN(32), .TIMEOUT_CYCLES(15), .SPLIT_MISALIGNED(0)) dut_b (
    .clk(clk), .reset(rst_n), .req_valid(vb), .req_ready(b_req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_rd(req_rd),
    .req_base(base32), .req_imm12(req_imm12), .req_wdata(wdata32),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_address(b_mem_address),
    .mem_be(b_mem_be), .mem_wdata(b_mem_wdata), .mem_rdata(rdata32), .mem_ack(mem_ack),
    .rsp_valid(b_rsp_valid), .rsp_rd(b_rsp_rd), .rsp_data(b_rsp_data),
    .rsp_write(b_rsp_write), .rsp_err(b_rsp_err), .busy(b_busy)
  );

  pe_mem_sequencer #(.XLEN(64), .TIMEOUT_CYCLES(4), .SPLIT_MISALIGNED(1)) dut_c (
    .clk(clk), .reset(rst_n), .req_valid(vc), .req_ready(c_req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_rd(req_rd),
    .req_base(base64), .req_imm12(req_imm12), .req_wdata(wdata64),
    .mem_read(c_mem_read), .mem_write(c_mem_write), .mem_address(c_mem_address),
    .mem_be(c_mem_be), .mem_wdata(c_mem_wdata), .mem_rdata(rdata64), .mem_ack(mem_ack),
    .rsp_valid(c_rsp_valid), .rsp_rd(c_rsp_rd), .rsp_data(c_rsp_data),
    .rsp_write(c_rsp_write), .rsp_err(c_rsp_err), .busy(c_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rv(input int d);
    return (d == 0) ? a_rsp_valid : ((d == 1) ? b_rsp_valid : c_rsp_valid);
  endfunction

  // Accept happens on the posedge between the two negedges; returns at negedge 1.
  task automatic send(input int d, input logic st, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [63:0] base, input logic [11:0] imm, input logic [63:0] wd);
    @(negedge clk);
    req_store  = st;
    req_funct3 = f3;
    req_rd     = rd;
    base32     = base[31:0];
    base64     = base;
    req_imm12  = imm;
    wdata32    = wd[31:0];
    wdata64    = wd;
    va = (d == 0);
    vb = (d == 1);
    vc = (d == 2);
    @(negedge clk);
    va = 1'b0;
    vb = 1'b0;
    vc = 1'b0;
  endtask

  // n counts negedges since accept; stops when rsp_valid is seen (bounded).
  task automatic wait_rsp(input int d, inout int n);
    for (int i = 0; i < 30; i++) begin
      if (rv(d)) break;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int cnt;
    logic seen;
    rst_n = 1'b0; va = 1'b0; vb = 1'b0; vc = 1'b0; mem_ack = 1'b0;
    req_store = 1'b0; req_funct3 = '0; req_rd = '0; req_imm12 = '0;
    base32 = '0; wdata32 = '0; rdata32 = '0; base64 = '0; wdata64 = '0; rdata64 = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", a_req_ready, 1);
    check("rst_busy", a_busy, 0);
    check("rst_mem_read", a_mem_read, 0);
    check("rst_rsp_valid", a_rsp_valid, 0);
    check("rst_rsp_err", a_rsp_err, 0);
    check("rst_ready_c", c_req_ready, 1);
    rst_n = 1'b1;

    // Stray ack while idle
    @(negedge clk); mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    check("stray_busy", a_busy, 0);
    check("stray_rsp", a_rsp_valid, 0);

    // LB at 0x100 + (-1) = 0xFF, two wait cycles
    rdata32 = 32'h8000_0000;
    send(0, 1'b0, 3'b000, 5'd5, 64'h100, 12'hFFF, 64'h0); n = 1;
    @(negedge clk); n++;
    check("lb_read", a_mem_read, 1);
    check("lb_addr", a_mem_address, 32'hFC);
    check("lb_be", a_mem_be, 4'b1000);
    @(negedge clk); n++;
    check("lb_read_hold", a_mem_read, 1);
    @(negedge clk); n++; mem_ack = 1'b1;
    @(negedge clk); n++; mem_ack = 1'b0;
    wait_rsp(0, n);
    check("lb_latency", n, 5);
    check("lb_data", a_rsp_data, 32'hFFFF_FF80);
    check("lb_write", a_rsp_write, 1);
    check("lb_rd", a_rsp_rd, 5);
    check("lb_err", a_rsp_err, 0);
    @(negedge clk);
    check("lb_pulse", a_rsp_valid, 0);
    check("lb_ready", a_req_ready, 1);

    // Aligned LW, zero wait
    rdata32 = 32'hDEAD_BEEF;
    send(0, 1'b0, 3'b010, 5'd7, 64'h200, 12'h004, 64'h0); n = 1;
    @(negedge clk); n++;
    check("lw_addr", a_mem_address, 32'h204);
    check("lw_be", a_mem_be, 4'hF);
    mem_ack = 1'b1;
    @(negedge clk); n++; mem_ack = 1'b0;
    wait_rsp(0, n);
    check("lw_latency", n, 3);
    check("lw_data", a_rsp_data, 32'hDEAD_BEEF);

    // SH crossing the word boundary at 0x10F
    send(0, 1'b1, 3'b001, 5'd9, 64'h10F, 12'h000, 64'h1234); n = 1;
    @(negedge clk); n++;
    check("shx_write1", a_mem_write, 1);
    check("shx_read1", a_mem_read, 0);
    check("shx_addr1", a_mem_address, 32'h10C);
    check("shx_be1", a_mem_be, 4'b1000);
    check("shx_wdata1", a_mem_wdata, 32'h3400_0000);
    mem_ack = 1'b1;
    @(negedge clk); n++; mem_ack = 1'b0;
    check("shx_addr2", a_mem_address, 32'h110);
    check("shx_be2", a_mem_be, 4'b0001);
    check("shx_wdata2", a_mem_wdata, 32'h0000_0012);
    check("shx_write2", a_mem_write, 1);
    mem_ack = 1'b1;
    @(negedge clk); n++; mem_ack = 1'b0;
    wait_rsp(0, n);
    check("shx_valid", a_rsp_valid, 1);
    check("shx_rsp_write", a_rsp_write, 0);
    check("shx_err", a_rsp_err, 0);

    // SH at 0x10E stays within one word
    send(0, 1'b1, 3'b001, 5'd9, 64'h10E, 12'h000, 64'hABCD_1234); n = 1;
    @(negedge clk); n++;
    check("sh_addr", a_mem_address, 32'h10C);
    check("sh_be", a_mem_be, 4'b1100);
    check("sh_wdata", a_mem_wdata, 32'h1234_0000);
    mem_ack = 1'b1;
    @(negedge clk); n++; mem_ack = 1'b0;
    wait_rsp(0, n);
    check("sh_latency", n, 3);
    check("sh_rsp_write", a_rsp_write, 0);

    // Misaligned LW at 0x102, split and merged
    send(0, 1'b0, 3'b010, 5'd3, 64'h100, 12'h002, 64'h0); n = 1;
    @(negedge clk); n++;
    check("lwx_addr1", a_mem_address, 32'h100);
    check("lwx_be1", a_mem_be, 4'b1100);
    rdata32 = 32'h4433_2211; mem_ack = 1'b1;
    @(negedge clk); n++; mem_ack = 1'b0;
    check("lwx_addr2", a_mem_address, 32'h104);
    check("lwx_be2", a_mem_be, 4'b0011);
    check("lwx_read2", a_mem_read, 1);
    rdata32 = 32'h8877_6655; mem_ack = 1'b1;
    @(negedge clk); n++; mem_ack = 1'b0;
    wait_rsp(0, n);
    check("lwx_data", a_rsp_data, 32'h6655_4433);
    check("lwx_write", a_rsp_write, 1);

    // Same access without splitting: misaligned error, no memory strobe
    send(1, 1'b0, 3'b010, 5'd3, 64'h100, 12'h002, 64'h0); n = 1;
    check("nosplit_read_addr", b_mem_read, 0);
    @(negedge clk); n++;
    wait_rsp(1, n);
    check("nosplit_latency", n, 2);
    check("nosplit_read", b_mem_read, 0);
    check("nosplit_err", b_rsp_err, 2'b01);
    check("nosplit_write", b_rsp_write, 0);

    // LD encoding on a 32-bit path is illegal
    send(0, 1'b0, 3'b011, 5'd4, 64'h200, 12'h000, 64'h0); n = 1;
    @(negedge clk); n++;
    wait_rsp(0, n);
    check("illegal_latency", n, 2);
    check("illegal_read", a_mem_read, 0);
    check("illegal_err", a_rsp_err, 2'b01);
    check("illegal_write", a_rsp_write, 0);

    // No ack: timeout after four strobe cycles
    send(0, 1'b0, 3'b010, 5'd6, 64'h300, 12'h000, 64'h0); n = 1; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); n++;
      if (a_mem_read) cnt++;
      if (a_rsp_valid) break;
    end
    check("to_strobe_cycles", cnt, 4);
    check("to_latency", n, 6);
    check("to_err", a_rsp_err, 2'b10);
    check("to_write", a_rsp_write, 0);

    // Ack in the last counted cycle is taken
    rdata32 = 32'hCAFE_F00D;
    send(0, 1'b0, 3'b010, 5'd6, 64'h300, 12'h000, 64'h0); n = 1;
    repeat (3) begin @(negedge clk); n++; end
    @(negedge clk); n++; mem_ack = 1'b1;
    @(negedge clk); n++; mem_ack = 1'b0;
    check("late_valid", a_rsp_valid, 1);
    check("late_err", a_rsp_err, 0);
    check("late_data", a_rsp_data, 32'hCAFE_F00D);
    check("late_write", a_rsp_write, 1);

    // Reset in the middle of ACC1
    send(0, 1'b0, 3'b010, 5'd8, 64'h400, 12'h000, 64'h0);
    @(negedge clk);
    check("rstmid_read_before", a_mem_read, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_read", a_mem_read, 0);
    check("rstmid_ready", a_req_ready, 1);
    check("rstmid_rsp", a_rsp_valid, 0);
    rst_n = 1'b1; mem_ack = 1'b1; seen = 1'b0;
    repeat (4) begin @(negedge clk); if (a_rsp_valid) seen = 1'b1; end
    mem_ack = 1'b0;
    check("rstmid_no_rsp", seen, 0);
    check("rstmid_idle", a_busy, 0);

    // 64-bit LD at 0x8
    rdata64 = 64'h1122_3344_5566_7788;
    send(2, 1'b0, 3'b011, 5'd12, 64'h8, 12'h000, 64'h0); n = 1;
    @(negedge clk); n++;
    check("ld_be", c_mem_be, 8'hFF);
    check("ld_addr", c_mem_address, 64'h8);
    mem_ack = 1'b1;
    @(negedge clk); n++; mem_ack = 1'b0;
    wait_rsp(2, n);
    check("ld_data", c_rsp_data, 64'h1122_3344_5566_7788);

    // 64-bit LWU and LW of 0x80000000 in the upper half
    rdata64 = 64'h8000_0000_0000_0000;
    send(2, 1'b0, 3'b110, 5'd13, 64'h0, 12'h004, 64'h0); n = 1;
    @(negedge clk); n++;
    check("lwu_be", c_mem_be, 8'hF0);
    check("lwu_addr", c_mem_address, 64'h0);
    mem_ack = 1'b1;
    @(negedge clk); n++; mem_ack = 1'b0;
    wait_rsp(2, n);
    check("lwu_data", c_rsp_data, 64'h0000_0000_8000_0000);
    send(2, 1'b0, 3'b010, 5'd14, 64'h0, 12'h004, 64'h0); n = 1;
    @(negedge clk); n++; mem_ack = 1'b1;
    @(negedge clk); n++; mem_ack = 1'b0;
    wait_rsp(2, n);
    check("lw64_data", c_rsp_data, 64'hFFFF_FFFF_8000_0000);
    check("lw64_rd", c_rsp_rd, 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
